// File: rtl/manchester_frame_deframer.sv
// ---------------------------------------------------------------------------
// manchester_frame_deframer
//
// Purpose: frames a recovered serial bit stream. The block hunts for a 16-bit
// sync word, then collects PAYLOAD_BITS payload bits and an 8-bit CRC
// (CRC-8, poly 0x07, init 0x00, MSB first). A CRC match publishes the
// payload. A mismatch, or loss of CDR lock mid-frame, counts as an error.
//
// Ports:
//   clk_link    in   link clock (200 MHz)
//   rst_n       in   synchronous active-low reset
//   bit_in      in   recovered bit, qualified by bit_valid
//   bit_valid   in   one-cycle strobe per recovered bit
//   cdr_locked  in   CDR lock status; bits are accepted only while locked
//   frame_data  out  payload of the last good frame
//   frame_valid out  one-cycle pulse when a good frame completes
//   crc_err     out  one-cycle pulse when a frame ends with a bad CRC
//   in_frame    out  high while collecting payload or CRC
//   good_cnt    out  saturating count of good frames
//   err_cnt     out  saturating count of CRC errors plus aborted frames
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module manchester_frame_deframer #(
  parameter logic [15:0] SYNC_WORD    = 16'hD5AA,
  parameter int          PAYLOAD_BITS = 32
) (
  input  logic                    clk_link,
  input  logic                    rst_n,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  input  logic                    cdr_locked,
  output logic [PAYLOAD_BITS-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    crc_err,
  output logic                    in_frame,
  output logic [15:0]             good_cnt,
  output logic [15:0]             err_cnt
);

  if (SYNC_WORD == 16'h0000 || PAYLOAD_BITS < 8 || PAYLOAD_BITS > 64 ||
      (PAYLOAD_BITS % 8) != 0) begin : g_bad_params
    $error("manchester_frame_deframer: illegal SYNC_WORD or PAYLOAD_BITS");
  end

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CRC     = 2'd2;

  // One counter serves both the payload and the 8-bit CRC phase.
  localparam int                CNT_W        = $clog2(PAYLOAD_BITS);
  localparam logic [CNT_W-1:0]  LAST_PAYLOAD = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_CRC     = CNT_W'(7);

  logic [1:0]              state;
  logic [15:0]             sreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [7:0]              crc;
  logic [7:0]              rx_crc;
  logic [PAYLOAD_BITS-1:0] payload;

  logic [15:0] sreg_next;
  logic [7:0]  crc_next;
  logic [7:0]  rx_crc_next;
  logic        crc_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: every output of an always_comb gets a value before any branch, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    sreg_next   = {sreg[14:0], bit_in};
    crc_next    = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? 8'h07 : 8'h00);
    rx_crc_next = {rx_crc[6:0], bit_in};
    // crc already holds the final payload CRC while in the CRC state.
    crc_ok      = (rx_crc_next == crc);
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_link) begin
    frame_valid <= 1'b0;
    crc_err     <= 1'b0;
    if (!rst_n) begin
      // NOTE: the payload shift register is reset along with the control
      // state; it is small, and a defined frame_data after reset needs it.
      state      <= HUNT;
      sreg       <= '0;
      bit_cnt    <= '0;
      crc        <= '0;
      rx_crc     <= '0;
      payload    <= '0;
      frame_data <= '0;
      in_frame   <= 1'b0;
      good_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        HUNT: begin
          if (!cdr_locked) begin
            sreg <= '0;
          end else if (bit_valid) begin
            sreg <= sreg_next;
            if (sreg_next == SYNC_WORD) begin
              state    <= PAYLOAD;
              in_frame <= 1'b1;
              bit_cnt  <= '0;
              crc      <= 8'h00;
            end
          end
        end

        PAYLOAD, CRC: begin
          if (!cdr_locked) begin
            // Lock lost mid-frame: drop it silently apart from the count.
            state    <= HUNT;
            in_frame <= 1'b0;
            sreg     <= '0;
            bit_cnt  <= '0;
            err_cnt  <= sat_inc(err_cnt);
          end else if (bit_valid) begin
            if (state == PAYLOAD) begin
              payload <= {payload[PAYLOAD_BITS-2:0], bit_in};
              crc     <= crc_next;
              if (bit_cnt == LAST_PAYLOAD) begin
                state   <= CRC;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              rx_crc <= rx_crc_next;
              if (bit_cnt == LAST_CRC) begin
                // Clearing sreg keeps CRC bits out of the next sync search.
                state    <= HUNT;
                in_frame <= 1'b0;
                sreg     <= '0;
                bit_cnt  <= '0;
                if (crc_ok) begin
                  frame_valid <= 1'b1;
                  frame_data  <= payload;
                  good_cnt    <= sat_inc(good_cnt);
                end else begin
                  crc_err <= 1'b1;
                  err_cnt <= sat_inc(err_cnt);
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state    <= HUNT;
          in_frame <= 1'b0;
          sreg     <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_frame_deframer.sv
// ---------------------------------------------------------------------------
// tb_manchester_frame_deframer
//
// Purpose: self-checking bench for manchester_frame_deframer. Frames are
// built from sync word, payload and CRC; the expected CRC comes from a
// polynomial long division over the payload, and a small model tracks the
// expected counters and published payload.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_manchester_frame_deframer;

  localparam logic [15:0] SYNC = 16'hD5AA;
  localparam int          PB   = 32;

  logic          clk_link   = 1'b0;
  logic          rst_n      = 1'b0;
  logic          bit_in     = 1'b0;
  logic          bit_valid  = 1'b0;
  logic          cdr_locked = 1'b0;
  logic [PB-1:0] frame_data;
  logic          frame_valid;
  logic          crc_err;
  logic          in_frame;
  logic [15:0]   good_cnt;
  logic [15:0]   err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitor
  int fv_seen      = 0;
  int ce_seen      = 0;
  int overlap_seen = 0;

  // Reference model state
  logic [15:0]   m_good = '0;
  logic [15:0]   m_err  = '0;
  logic [PB-1:0] m_data = '0;
  int            m_frames_good = 0;
  int            m_frames_bad  = 0;

  manchester_frame_deframer #(
    .SYNC_WORD   (SYNC),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk_link   (clk_link),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .cdr_locked (cdr_locked),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .crc_err    (crc_err),
    .in_frame   (in_frame),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt)
  );

  always #2.5 clk_link = ~clk_link;

  always @(negedge clk_link) begin
    if (frame_valid) fv_seen++;
    if (crc_err) ce_seen++;
    if (frame_valid && crc_err) overlap_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-8 as the remainder of payload * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc8_ref(input logic [PB-1:0] p);
    logic [PB+7:0] m;
    m = {p, 8'h00};
    for (int i = PB + 7; i >= 8; i--)
      if (m[i]) m[i-:9] = m[i-:9] ^ 9'h107;
    return m[7:0];
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PB-1:0] rand_payload();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PB-1:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_link);
      #1;
    end
  endtask

  // Presents one bit for one cycle; the next bit may follow gap cycles later.
  task automatic send_bit(input logic b, input int gap);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk_link);
    #1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    idle(gap - 1);
  endtask

  task automatic send_sync(input int gap);
    for (int i = 15; i >= 0; i--) send_bit(SYNC[i], gap);
  endtask

  task automatic send_frame(input logic [PB-1:0] p, input logic [7:0] c, input int gap);
    logic good;
    send_sync(gap);
    check("in_frame_after_sync", 64'(in_frame), 64'(1'b1));
    for (int i = PB - 1; i >= 0; i--) send_bit(p[i], gap);
    for (int i = 7; i >= 1; i--) send_bit(c[i], gap);
    send_bit(c[0], 1);
    good = (c == crc8_ref(p));
    if (good) begin
      m_good = sat(m_good);
      m_data = p;
      m_frames_good++;
    end else begin
      m_err = sat(m_err);
      m_frames_bad++;
    end
    check("frame_valid_at_end", 64'(frame_valid), 64'(good));
    check("crc_err_at_end", 64'(crc_err), 64'(!good));
    check("frame_data", 64'(frame_data), 64'(m_data));
    check("good_cnt", 64'(good_cnt), 64'(m_good));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    check("in_frame_after_end", 64'(in_frame), 64'(1'b0));
    idle(gap - 1);
  endtask

  initial begin
    logic [PB-1:0] p;
    logic [15:0]   win;
    logic          nb;
    int            hunt_bad;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    check("rst_frame_data", 64'(frame_data), 64'(0));
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_crc_err", 64'(crc_err), 64'(0));
    check("rst_in_frame", 64'(in_frame), 64'(0));
    check("rst_good_cnt", 64'(good_cnt), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    rst_n      = 1'b1;
    cdr_locked = 1'b1;
    idle(2);

    // Directed good/bad frames
    send_frame('0, 8'h00, 2);
    send_frame({PB{1'b1}}, 8'hDE, 3);
    send_frame({PB{1'b1}}, 8'hDF, 2);

    // Lock drop after 10 payload bits; the bit strobed while unlocked is ignored
    send_sync(1);
    p = rand_payload();
    for (int i = PB - 1; i >= PB - 10; i--) send_bit(p[i], 2);
    cdr_locked = 1'b0;
    bit_valid  = 1'b1;
    @(posedge clk_link);
    #1;
    bit_valid = 1'b0;
    m_err     = sat(m_err);
    check("lockdrop_in_frame", 64'(in_frame), 64'(0));
    check("lockdrop_err_cnt", 64'(err_cnt), 64'(m_err));
    check("lockdrop_no_fv", 64'(frame_valid), 64'(0));
    check("lockdrop_no_ce", 64'(crc_err), 64'(0));
    cdr_locked = 1'b1;
    idle(2);
    p = rand_payload();
    send_frame(p, crc8_ref(p), 2);

    // Lock low in HUNT splits the sync word, so it must not be found
    for (int i = 15; i >= 8; i--) send_bit(SYNC[i], 1);
    cdr_locked = 1'b0;
    idle(1);
    cdr_locked = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 1);
    check("split_sync_in_frame", 64'(in_frame), 64'(0));
    idle(1);

    // Sync rejection: 0xD5AB then random bits never forming the sync word
    hunt_bad = 0;
    win      = '0;
    begin
      logic [15:0] near;
      near = 16'hD5AB;
      for (int i = 15; i >= 0; i--) begin
        win = {win[14:0], near[i]};
        send_bit(near[i], 1);
        if (in_frame || frame_valid || crc_err) hunt_bad++;
      end
    end
    for (int k = 0; k < 200; k++) begin
      nb = 1'($urandom_range(0, 1));
      if ({win[14:0], nb} == SYNC) nb = ~nb;
      win = {win[14:0], nb};
      send_bit(nb, 1 + (k % 3));
      if (in_frame || frame_valid || crc_err) hunt_bad++;
    end
    check("sync_reject_stays_hunt", 64'(hunt_bad), 64'(0));
    cdr_locked = 1'b0;
    idle(1);
    cdr_locked = 1'b1;
    idle(1);

    // Reset mid-frame discards the frame and clears everything
    send_sync(1);
    p = rand_payload();
    for (int i = PB - 1; i >= PB - 12; i--) send_bit(p[i], 1);
    rst_n = 1'b0;
    idle(1);
    m_good = '0;
    m_err  = '0;
    m_data = '0;
    check("midrst_in_frame", 64'(in_frame), 64'(0));
    check("midrst_good_cnt", 64'(good_cnt), 64'(0));
    check("midrst_err_cnt", 64'(err_cnt), 64'(0));
    check("midrst_frame_data", 64'(frame_data), 64'(0));
    check("midrst_no_pulse", 64'({frame_valid, crc_err}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Random frames, mostly good, random bit spacing
    for (int f = 0; f < 12; f++) begin
      logic [7:0] c;
      p = rand_payload();
      c = crc8_ref(p);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      send_frame(p, c, $urandom_range(1, 5));
    end

    // Saturation: preset good_cnt, then three back-to-back frames at 4-cycle spacing
    force dut.good_cnt = 16'hFFFE;
    idle(1);
    release dut.good_cnt;
    idle(1);
    m_good = 16'hFFFE;
    check("preset_good_cnt", 64'(good_cnt), 64'(m_good));
    begin
      int fv_before;
      fv_before = fv_seen;
      for (int f = 0; f < 3; f++) begin
        p = rand_payload();
        send_frame(p, crc8_ref(p), 4);
      end
      check("b2b_pulse_count", 64'(fv_seen - fv_before), 64'(3));
    end
    check("good_cnt_saturated", 64'(good_cnt), 64'(16'hFFFF));

    // Whole-run pulse accounting (also catches pulses wider than one cycle)
    idle(3);
    check("total_frame_valid_pulses", 64'(fv_seen), 64'(m_frames_good));
    check("total_crc_err_pulses", 64'(ce_seen), 64'(m_frames_bad));
    check("pulse_overlap", 64'(overlap_seen), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
